divider1: RTL and testbench
===========================

DIVIDER1 -- requirements
Module: divider1

Interface
REQ-001 SHALL have parameter N, default 8, operand width; the dividend is 2N bits, the divisor, quotient and remainder are N bits each.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: request to begin a division, sampled on the rising edge of clk.
REQ-005 SHALL have port A, input, 2N bits: unsigned dividend, sampled only on the accepting edge.
REQ-006 SHALL have port B, input, N bits: unsigned divisor, sampled only on the accepting edge.
REQ-007 SHALL have port Quotient, output, N bits: registered quotient.
REQ-008 SHALL have port Remainder, output, N bits: registered remainder.
REQ-009 SHALL have port Ovf, output, 1 bit: divisor is zero or the quotient does not fit in N bits.
REQ-010 SHALL have port ready, output, 1 bit: idle, with the outputs holding the last valid result.

Function
REQ-011 SHALL implement an FSM with states IDLE, CHECK and BUSY; ready=1 only in IDLE.
REQ-012 SHALL accept start only in IDLE; the accepting edge is E0.
- At E0: register A and B, clear Ovf, go to CHECK, drop ready.
REQ-013 SHALL ignore start in CHECK and BUSY; A and B may be X after E0 without effect.
REQ-014 SHALL, at E1 (CHECK), detect overflow when B==0 or A[2N-1:N] >= B.
- On overflow: Quotient=all-ones, Remainder=0, Ovf=1, return to IDLE (ready=1 after E1).
REQ-015 SHALL otherwise, at E1, load partial remainder R=A[2N-1:N] and Q=A[N-1:0], clear the iteration counter and enter BUSY.
REQ-016 SHALL perform one restoring step per cycle in BUSY, MSB first.
- Shift {R,Q} left by 1 into an N+1-bit trial T={carry,R'}.
- If T>=B: R=T-B and Q[0]=1; else R=R' and Q[0]=0.
REQ-017 SHALL perform exactly N steps, at edges E2..E(N+1).
- At E(N+1): Quotient=Q, Remainder=R, Ovf=0, go to IDLE.
- With N=8, ready rises after E9 and stays high until the next accepted start.
REQ-018 SHALL guarantee, for every non-overflow result, Quotient*B+Remainder == A and Remainder < B.
REQ-019 SHALL hold Quotient, Remainder and Ovf stable from the result edge until the next accepted start; they are undefined from E0 until ready rises.
REQ-020 SHALL accept a start asserted in the same cycle ready rises at the next edge, giving back-to-back operation with no dead cycle.

Reset
REQ-021 SHALL, while rst=1 at a rising edge, force:
- state=IDLE, ready=1, Quotient=0, Remainder=0, Ovf=0;
- all internal registers and the iteration counter cleared.
REQ-022 SHALL abort any division in progress when reset is asserted mid-operation, leave no residual state, and give rst priority over start in the same cycle.

Structure
REQ-023 SHALL take the state enumeration and the default N from a shared package divider1_pkg.
REQ-024 SHALL place the single compare/subtract/shift step in a purely combinational sub-module divider1_step (ports R, Q, B in; R_next, Q_next out).
- divider1 instantiates it once and owns all registers.

Verification
REQ-025 SHALL test a nominal division: A=16'h1234, B=8'h56 -> after E9: Quotient=8'h36, Remainder=8'h10, Ovf=0, ready=1.
REQ-026 SHALL test the largest non-overflow case: A=16'hFEFF, B=8'hFF -> Quotient=8'hFF, Remainder=8'hFE, Ovf=0.
REQ-027 SHALL test both overflow paths:
- A=16'h0010, B=0 -> after E1: Ovf=1, Quotient=8'hFF, Remainder=0, ready=1.
- A=16'h0500, B=8'h05 -> same overflow result.
REQ-028 SHALL test start pulses at E3 and E5 during a busy division (A=16'd100, B=8'd7) -> both ignored; result Quotient=14, Remainder=2 after E9.
REQ-029 SHALL test rst asserted at E4 of a division -> next cycle ready=1 and outputs 0; a following start with A=16'd255, B=8'd16 gives Quotient=15, Remainder=15.
REQ-030 SHALL run 100 random trials with a back-to-back start each time ready rises -> every non-overflow result satisfies Quotient*B+Remainder==A and Remainder<B, and every overflow matches REQ-014.

Source files
------------

// File: rtl/divider1_pkg.sv
// Shared definitions for the divider1 restoring divider: default operand
// width and the control FSM state encoding.
package divider1_pkg;
  localparam int N_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    BUSY  = 2'd2
  } state_t;
endpackage

// File: rtl/divider1_step.sv
// One restoring division step: shift {R,Q} left by one and conditionally
// subtract the divisor, producing the next partial remainder and quotient.
module divider1_step
  import divider1_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic [N-1:0] R,
  input  logic [N-1:0] Q,
  input  logic [N-1:0] B,
  output logic [N-1:0] R_next,
  output logic [N-1:0] Q_next
);

  logic [N:0] trial;
  logic [N:0] diff;

  // The trial keeps the bit shifted out of R so a remainder close to 2^N
  // still compares correctly against B.
  assign trial = {R, Q[N-1]};
  assign diff  = trial - {1'b0, B};

  always_comb begin
    R_next = trial[N-1:0];
    Q_next = {Q[N-2:0], 1'b0};
    if (trial >= {1'b0, B}) begin
      R_next = diff[N-1:0];
      Q_next = {Q[N-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/divider1.sv
// Sequential unsigned 2N/N restoring divider: one overflow-check cycle
// followed by N shift/subtract cycles, with a start/ready handshake.
module divider1
  import divider1_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*N-1:0] A,
  input  logic [N-1:0]   B,
  output logic [N-1:0]   Quotient,
  output logic [N-1:0]   Remainder,
  output logic           Ovf,
  output logic           ready
);

  localparam int CW = $clog2(N + 1);

  state_t         state, state_next;
  logic [2*N-1:0] a_r;
  logic [N-1:0]   b_r;
  logic [N-1:0]   r_r;
  logic [N-1:0]   q_r;
  logic [CW-1:0]  cnt;
  logic [N-1:0]   r_next;
  logic [N-1:0]   q_next;
  logic           ovf_det;
  logic           last_step;

  divider1_step #(.N(N)) u_step (
    .R      (r_r),
    .Q      (q_r),
    .B      (b_r),
    .R_next (r_next),
    .Q_next (q_next)
  );

  // A high half not below B means the quotient cannot fit in N bits;
  // B==0 is caught by the same compare but kept explicit for clarity.
  assign ovf_det   = (b_r == '0) || (a_r[2*N-1:N] >= b_r);
  assign last_step = (cnt == CW'(N - 1));
  assign ready     = (state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CHECK;
      CHECK:   state_next = ovf_det ? IDLE : BUSY;
      BUSY:    if (last_step) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_r       <= '0;
      b_r       <= '0;
      r_r       <= '0;
      q_r       <= '0;
      cnt       <= '0;
      Quotient  <= '0;
      Remainder <= '0;
      Ovf       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_r <= A;
            b_r <= B;
            Ovf <= 1'b0;
          end
        end
        CHECK: begin
          if (ovf_det) begin
            Quotient  <= '1;
            Remainder <= '0;
            Ovf       <= 1'b1;
          end else begin
            r_r <= a_r[2*N-1:N];
            q_r <= a_r[N-1:0];
            cnt <= '0;
          end
        end
        BUSY: begin
          r_r <= r_next;
          q_r <= q_next;
          cnt <= cnt + 1'b1;
          if (last_step) begin
            Quotient  <= q_next;
            Remainder <= r_next;
            Ovf       <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divider1.sv
// Directed and randomized self-checking bench for divider1 (N=8).
module tb_divider1;
  localparam int N = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [2*N-1:0] A;
  logic [N-1:0]   B;
  logic [N-1:0]   Quotient;
  logic [N-1:0]   Remainder;
  logic           Ovf;
  logic           ready;

  int checks = 0;
  int errors = 0;

  divider1 #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .A         (A),
    .B         (B),
    .Quotient  (Quotient),
    .Remainder (Remainder),
    .Ovf       (Ovf),
    .ready     (ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge with ready high; returns just after the accepting edge.
  task automatic launch(input logic [2*N-1:0] a, input logic [N-1:0] b);
    A = a;
    B = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    A = 16'($urandom);
    B = 8'($urandom);
  endtask

  // Counts negedges until ready is seen high; lat=10 means ready rose after E9.
  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!ready && lat < 40);
    if (!ready) chk("timeout", 32'(ready), 32'd1);
  endtask

  task automatic expect_result(input string tag, input logic [N-1:0] q,
                               input logic [N-1:0] r, input logic o);
    chk({tag, "_q"}, 32'(Quotient), 32'(q));
    chk({tag, "_r"}, 32'(Remainder), 32'(r));
    chk({tag, "_ovf"}, 32'(Ovf), 32'(o));
  endtask

  initial begin
    int lat;
    logic [2*N-1:0] ra;
    logic [N-1:0]   rb;
    logic [N-1:0]   eq, er;
    logic           eo;
    logic [N-1:0]   hi;

    rst = 1'b1;
    start = 1'b0;
    A = '0;
    B = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_ready", 32'(ready), 32'd1);
    expect_result("reset", 8'h00, 8'h00, 1'b0);

    // Nominal division with latency and ready checks
    launch(16'h1234, 8'h56);
    @(negedge clk);
    chk("busy_ready_low", 32'(ready), 32'd0);
    wait_done(lat);
    chk("nominal_latency", 32'(lat + 1), 32'd10);
    expect_result("nominal", 8'h36, 8'h10, 1'b0);
    repeat (3) @(negedge clk);
    expect_result("hold", 8'h36, 8'h10, 1'b0);

    launch(16'hFEFF, 8'hFF);
    wait_done(lat);
    chk("max_latency", 32'(lat), 32'd10);
    expect_result("max", 8'hFF, 8'hFE, 1'b0);

    launch(16'h0010, 8'h00);
    wait_done(lat);
    chk("div0_latency", 32'(lat), 32'd2);
    expect_result("div0", 8'hFF, 8'h00, 1'b1);

    launch(16'h0500, 8'h05);
    wait_done(lat);
    chk("ovf_latency", 32'(lat), 32'd2);
    expect_result("ovf", 8'hFF, 8'h00, 1'b1);

    // Start pulses at E3 and E5 while busy
    launch(16'd100, 8'd7);
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(lat);
    chk("ignore_latency", 32'(lat + 5), 32'd10);
    expect_result("ignore", 8'd14, 8'd2, 1'b0);

    // Reset at E4 of a division
    launch(16'd1000, 8'd9);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_ready", 32'(ready), 32'd1);
    expect_result("abort", 8'h00, 8'h00, 1'b0);
    launch(16'd255, 8'd16);
    wait_done(lat);
    chk("after_abort_latency", 32'(lat), 32'd10);
    expect_result("after_abort", 8'd15, 8'd15, 1'b0);

    // Random back-to-back trials: next start is driven the cycle ready is seen
    for (int t = 0; t < 100; t++) begin
      rb = 8'($urandom);
      if (t % 10 == 3) rb = 8'h00;
      if (rb != 0 && (t % 7) != 5) begin
        hi = 8'($urandom_range(0, 32'(rb) - 1));
        ra = {hi, 8'($urandom)};
      end else begin
        ra = 16'($urandom);
      end
      if (rb == 0 || ra[15:8] >= rb) begin
        eq = 8'hFF;
        er = 8'h00;
        eo = 1'b1;
      end else begin
        eq = 8'(ra / 16'(rb));
        er = 8'(ra % 16'(rb));
        eo = 1'b0;
      end
      launch(ra, rb);
      wait_done(lat);
      expect_result("rand", eq, er, eo);
      if (!eo) begin
        chk("rand_identity", 32'(Quotient) * 32'(rb) + 32'(Remainder), 32'(ra));
        chk("rand_rem_lt_b", 32'(Remainder < rb), 32'd1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
